// File: rtl/hue_rgbw_engine.sv
// Hue-wheel / RGB-to-RGBW colour engine. Each channel is scaled by an external
// handshaked multiplier, then all four outputs update together.
module hue_rgbw_engine #(
  parameter int         DW           = 8,
  parameter logic [7:0] MODE_DIRECT  = 8'h21,
  parameter logic [7:0] MODE_WHEEL   = 8'hA4,
  parameter logic [7:0] MODE_EXTRACT = 8'h5A
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      mode,
  input  logic [DW-1:0]   lint,
  input  logic [DW-1:0]   color_idx,
  input  logic [DW-1:0]   white_in,
  input  logic [DW-1:0]   red_in,
  input  logic [DW-1:0]   green_in,
  input  logic [DW-1:0]   blue_in,
  output logic [DW-1:0]   mult1,
  output logic [DW-1:0]   mult2,
  output logic            ld,
  input  logic            mult_ok,
  input  logic [2*DW-1:0] mult_res,
  output logic [DW-1:0]   red_out,
  output logic [DW-1:0]   green_out,
  output logic [DW-1:0]   blue_out,
  output logic [DW-1:0]   white_out,
  output logic            out_valid,
  output logic            busy
);

  localparam logic [DW-1:0] MAX = {DW{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_HUE = 4'd1, S_SAT = 4'd2, S_EXTRACT = 4'd3,
    S_MUL_W = 4'd4, S_MUL_R = 4'd5, S_MUL_G = 4'd6, S_MUL_B = 4'd7, S_OUT = 4'd8
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   lint_q, lint_d, idx_q, idx_d;
  logic [DW-1:0]   w_q, w_d, r_q, r_d, g_q, g_d, b_q, b_d;
  logic [DW-1:0]   ro_q, ro_d, go_q, go_d, bo_q, bo_d, wo_q, wo_d;
  logic            ld_q, ld_d, ov_q, ov_d;

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW] ? MAX : s[DW-1:0];
  endfunction

  // idx*6 as shift-add; the top three bits select the wheel sector
  logic [DW+2:0] p;
  logic [2:0]    sector;
  logic [DW-1:0] up, dn, mn_rg, mn;
  assign p      = ({3'b000, idx_q} << 2) + ({3'b000, idx_q} << 1);
  assign sector = p[DW+2:DW];
  assign up     = p[DW-1:0];
  assign dn     = MAX - up;
  assign mn_rg  = (r_q < g_q) ? r_q : g_q;
  assign mn     = (mn_rg < b_q) ? mn_rg : b_q;

  logic          mul_st;
  logic [DW-1:0] chan;
  logic [2*DW-1:0] prod_sum;
  assign mul_st = (state_q == S_MUL_W) || (state_q == S_MUL_R) ||
                  (state_q == S_MUL_G) || (state_q == S_MUL_B);

  always_comb begin
    chan = '0;
    case (state_q)
      S_MUL_W: chan = w_q;
      S_MUL_R: chan = r_q;
      S_MUL_G: chan = g_q;
      S_MUL_B: chan = b_q;
      default: chan = '0;
    endcase
  end

  assign mult1 = mul_st ? lint_q : '0;
  assign mult2 = chan;
  // x*(lint+1) = x*lint + x, so full and zero intensity are exact
  assign prod_sum = mult_res + {{DW{1'b0}}, mult2};

  always_comb begin
    state_d = state_q;
    lint_d = lint_q; idx_d = idx_q;
    w_d = w_q; r_d = r_q; g_d = g_q; b_d = b_q;
    ro_d = ro_q; go_d = go_q; bo_d = bo_q; wo_d = wo_q;
    ld_d = ld_q;
    ov_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        ld_d = 1'b0;
        lint_d = lint; idx_d = color_idx;
        w_d = white_in; r_d = red_in; g_d = green_in; b_d = blue_in;
        if (mode == MODE_DIRECT) begin
          ro_d = red_in; go_d = green_in; bo_d = blue_in; wo_d = white_in;
          ov_d = 1'b1;
        end else if (mode == MODE_WHEEL) begin
          state_d = S_HUE;
        end else if (mode == MODE_EXTRACT) begin
          state_d = S_EXTRACT;
        end
      end
      S_HUE: begin
        state_d = S_SAT;
        case (sector)
          3'd0:    begin r_d = MAX; g_d = up;  b_d = '0;  end
          3'd1:    begin r_d = dn;  g_d = MAX; b_d = '0;  end
          3'd2:    begin r_d = '0;  g_d = MAX; b_d = up;  end
          3'd3:    begin r_d = '0;  g_d = dn;  b_d = MAX; end
          3'd4:    begin r_d = up;  g_d = '0;  b_d = MAX; end
          default: begin r_d = MAX; g_d = '0;  b_d = dn;  end
        endcase
      end
      S_SAT: begin
        r_d = sat_add(r_q, w_q);
        g_d = sat_add(g_q, w_q);
        b_d = sat_add(b_q, w_q);
        state_d = S_MUL_W;
      end
      S_EXTRACT: begin
        w_d = mn;
        r_d = r_q - mn; g_d = g_q - mn; b_d = b_q - mn;
        state_d = S_MUL_W;
      end
      S_MUL_W, S_MUL_R, S_MUL_G, S_MUL_B: begin
        if (ld_q) begin
          if (mult_ok) begin
            ld_d = 1'b0;
            case (state_q)
              S_MUL_W: begin w_d = prod_sum[2*DW-1:DW]; state_d = S_MUL_R; end
              S_MUL_R: begin r_d = prod_sum[2*DW-1:DW]; state_d = S_MUL_G; end
              S_MUL_G: begin g_d = prod_sum[2*DW-1:DW]; state_d = S_MUL_B; end
              S_MUL_B: begin b_d = prod_sum[2*DW-1:DW]; state_d = S_OUT;   end
              default: state_d = S_IDLE;
            endcase
          end
        end else if (!mult_ok) begin
          // wait for the previous done to clear before the next request
          ld_d = 1'b1;
        end
      end
      S_OUT: begin
        ro_d = r_q; go_d = g_q; bo_d = b_q; wo_d = w_q;
        ov_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      lint_q <= '0; idx_q <= '0;
      w_q <= '0; r_q <= '0; g_q <= '0; b_q <= '0;
      ro_q <= '0; go_q <= '0; bo_q <= '0; wo_q <= '0;
      ld_q <= 1'b0; ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lint_q <= lint_d; idx_q <= idx_d;
      w_q <= w_d; r_q <= r_d; g_q <= g_d; b_q <= b_d;
      ro_q <= ro_d; go_q <= go_d; bo_q <= bo_d; wo_q <= wo_d;
      ld_q <= ld_d; ov_q <= ov_d;
    end
  end

  assign ld        = ld_q;
  assign out_valid = ov_q;
  assign busy      = (state_q != S_IDLE);
  assign red_out   = ro_q;
  assign green_out = go_q;
  assign blue_out  = bo_q;
  assign white_out = wo_q;

endmodule

// File: tb/tb_hue_rgbw_engine.sv
// Scoreboard bench for hue_rgbw_engine: driver pushes reference results,
// a negedge monitor pops them whenever out_valid is seen.
module tb_hue_rgbw_engine;

  localparam int MD = 8'h21, MW = 8'hA4, ME = 8'h5A;

  logic        clk, reset;
  logic [7:0]  mode, lint, color_idx, white_in, red_in, green_in, blue_in;
  logic [7:0]  mult1, mult2, red_out, green_out, blue_out, white_out;
  logic        ld, mult_ok, out_valid, busy;
  logic [15:0] mult_res;

  hue_rgbw_engine dut (
    .clk(clk), .reset(reset), .mode(mode), .lint(lint), .color_idx(color_idx),
    .white_in(white_in), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .mult1(mult1), .mult2(mult2), .ld(ld), .mult_ok(mult_ok), .mult_res(mult_res),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out), .white_out(white_out),
    .out_valid(out_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier: done two cycles after a request, cleared one cycle after it drops
  logic [1:0] mcnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mult_ok <= 1'b0; mult_res <= '0; mcnt <= '0;
    end else if (ld && !mult_ok) begin
      if (mcnt == 2'd1) begin
        mult_ok <= 1'b1; mult_res <= mult1 * mult2; mcnt <= '0;
      end else mcnt <= mcnt + 2'd1;
    end else if (!ld && mult_ok) begin
      mult_ok <= 1'b0;
    end
  end

  typedef struct { int r; int g; int b; int w; } rgbw_t;
  rgbw_t exp_q[$];
  rgbw_t last;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sc(input int x, input int l);
    return (x * (l + 1)) / 256;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference: colour wheel or white extraction, then intensity scaling
  function automatic rgbw_t ref_calc(input int m, input int l, input int idx,
                                     input int w, input int r, input int g, input int b);
    rgbw_t e;
    int s, u, d, mn;
    if (m == MD) begin
      e.r = r; e.g = g; e.b = b; e.w = w;
      return e;
    end
    if (m == MW) begin
      s = (idx * 6) / 256; u = (idx * 6) % 256; d = 255 - u;
      case (s)
        0: begin e.r = 255; e.g = u;   e.b = 0;   end
        1: begin e.r = d;   e.g = 255; e.b = 0;   end
        2: begin e.r = 0;   e.g = 255; e.b = u;   end
        3: begin e.r = 0;   e.g = d;   e.b = 255; end
        4: begin e.r = u;   e.g = 0;   e.b = 255; end
        default: begin e.r = 255; e.g = 0; e.b = d; end
      endcase
      e.r = min2(e.r + w, 255); e.g = min2(e.g + w, 255); e.b = min2(e.b + w, 255);
      e.w = w;
    end else begin
      mn = min2(min2(r, g), b);
      e.w = mn; e.r = r - mn; e.g = g - mn; e.b = b - mn;
    end
    e.r = sc(e.r, l); e.g = sc(e.g, l); e.b = sc(e.b, l); e.w = sc(e.w, l);
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_valid got 1 expected 0");
      end else begin
        rgbw_t e;
        e = exp_q.pop_front();
        chk("red_out", int'(red_out), e.r);
        chk("green_out", int'(green_out), e.g);
        chk("blue_out", int'(blue_out), e.b);
        chk("white_out", int'(white_out), e.w);
        last = e;
      end
    end
  end

  task automatic issue(input int m, input int l, input int idx,
                       input int w, input int r, input int g, input int b);
    int n;
    bit known;
    n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    mode = 8'(m); lint = 8'(l); color_idx = 8'(idx);
    white_in = 8'(w); red_in = 8'(r); green_in = 8'(g); blue_in = 8'(b);
    known = (m == MD) || (m == MW) || (m == ME);
    if (known) exp_q.push_back(ref_calc(m, l, idx, w, r, g, b));
    @(posedge clk); #1;
    mode = 8'h00;
    if (m == MD || !known) chk("busy_in_idle", int'(busy), 0);
    n = 0;
    // inputs are scrambled while busy: the engine must ignore them
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      lint = 8'($urandom); color_idx = 8'($urandom); white_in = 8'($urandom);
      red_in = 8'($urandom); green_in = 8'($urandom); blue_in = 8'($urandom);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL result_timeout got none expected %0d results", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    chk("out_valid_pulse_end", int'(out_valid), 0);
    chk("idle_after_run", int'(busy), 0);
    if (!known) begin
      chk("hold_red", int'(red_out), last.r);
      chk("hold_green", int'(green_out), last.g);
      chk("hold_blue", int'(blue_out), last.b);
      chk("hold_white", int'(white_out), last.w);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ld"}, int'(ld), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_mult1"}, int'(mult1), 0);
    chk({tag, "_mult2"}, int'(mult2), 0);
    chk({tag, "_red"}, int'(red_out), 0);
    chk({tag, "_green"}, int'(green_out), 0);
    chk({tag, "_blue"}, int'(blue_out), 0);
    chk({tag, "_white"}, int'(white_out), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, n, sel, jm, l;
    logic prev;
    last = '{0, 0, 0, 0};
    reset = 1'b0; mode = 8'h00; lint = 8'h00; color_idx = 8'h00;
    white_in = 8'h00; red_in = 8'h00; green_in = 8'h00; blue_in = 8'h00;
    #1;
    reset_checks("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    issue(MD, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40);
    issue(MW, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    issue(MW, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
    issue(MW, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    issue(MW, 8'h80, 8'h2B, 8'h10, 8'h00, 8'h00, 8'h00);
    issue(ME, 8'hFF, 8'h00, 8'h00, 8'h64, 8'h30, 8'h50);
    issue(ME, 8'h00, 8'h00, 8'h00, 8'h64, 8'h30, 8'h50);
    issue(8'h33, 8'hFF, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44);

    // Reset during the third multiplier handshake (green channel)
    n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    mode = 8'(MW); lint = 8'h77; color_idx = 8'h40; white_in = 8'h05;
    @(posedge clk); #1;
    mode = 8'h00;
    rises = 0; prev = ld; n = 0;
    while (rises < 3 && n < 200) begin
      @(posedge clk); #1;
      if (ld && !prev) rises++;
      prev = ld; n++;
    end
    chk("ld_rises_before_reset", rises, 3);
    #2 reset = 1'b0;
    #1;
    reset_checks("midrun_reset");
    exp_q.delete();
    last = '{0, 0, 0, 0};
    @(negedge clk);
    reset = 1'b1;
    issue(MW, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      case ($urandom_range(0, 4))
        0: l = 0;
        1: l = 255;
        default: l = $urandom_range(0, 255);
      endcase
      if (sel == 3) begin
        do jm = $urandom_range(0, 255); while (jm == MD || jm == MW || jm == ME);
      end else jm = (sel == 0) ? MD : ((sel == 1) ? MW : ME);
      issue(jm, l, $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
